// File: rtl/ex_operand_stage_pkg.sv
// rtl/ex_operand_stage_pkg.sv - shared datapath encodings for the operand stage
package ex_operand_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_EX  = 2'b10
    } fwd_sel_e;

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == {STALL_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ex_operand_stage_operand_forward.sv
// rtl/ex_operand_stage_operand_forward.sv - bypass mux for one source operand
module operand_forward
    import ex_operand_stage_pkg::*;
(
    input  logic [REG_AW-1:0] src_addr_i,
    input  logic [XLEN-1:0]   rf_data_i,
    input  logic              ex_valid_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic [XLEN-1:0]   ex_result_i,
    input  logic              mem_reg_write_i,
    input  logic [REG_AW-1:0] mem_rd_addr_i,
    input  logic [XLEN-1:0]   mem_result_i,
    output logic [XLEN-1:0]   fwd_data_o
);

    fwd_sel_e sel;

    // A load in EX has no data yet; the load-use bubble covers that case.
    always_comb begin
        sel = FWD_REG;
        if (src_addr_i != '0) begin
            if (ex_valid_i && ex_reg_write_i && !ex_mem_read_i && (ex_rd_addr_i == src_addr_i))
                sel = FWD_EX;
            else if (mem_reg_write_i && (mem_rd_addr_i == src_addr_i))
                sel = FWD_MEM;
        end
    end

    always_comb begin
        fwd_data_o = rf_data_i;
        case (sel)
            FWD_EX:  fwd_data_o = ex_result_i;
            FWD_MEM: fwd_data_o = mem_result_i;
            default: fwd_data_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX operand register with forwarding and load-use stall
module ex_operand_stage
    import ex_operand_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [REG_AW-1:0]  id_rs1_addr,
    input  logic [REG_AW-1:0]  id_rs2_addr,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [REG_AW-1:0]  id_rd_addr,
    input  logic               id_alu_src,
    input  logic [2:0]         id_alu_control,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               flush,
    input  logic               ex_ready,
    input  logic [XLEN-1:0]    ex_alu_result,
    input  logic [REG_AW-1:0]  mem_rd_addr,
    input  logic               mem_reg_write,
    input  logic [XLEN-1:0]    mem_result,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_a,
    output logic [XLEN-1:0]    ex_b,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [2:0]         ex_alu_control,
    output logic [REG_AW-1:0]  ex_rd_addr,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic [STALL_W-1:0] stall_count
);

    logic               ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]    ex_a_q, ex_a_d;
    logic [XLEN-1:0]    ex_b_q, ex_b_d;
    logic [XLEN-1:0]    ex_sd_q, ex_sd_d;
    logic [2:0]         ex_ctl_q, ex_ctl_d;
    logic [REG_AW-1:0]  ex_rd_q, ex_rd_d;
    logic               ex_rw_q, ex_rw_d;
    logic               ex_mr_q, ex_mr_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic            load_use;
    logic            hold;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    assign load_use = ex_valid_q & ex_mr_q & (ex_rd_q != '0) & id_valid &
                      ((id_rs1_addr == ex_rd_q) | (id_rs2_addr == ex_rd_q));
    assign hold     = ex_valid_q & ~ex_ready;
    assign id_ready = (~ex_valid_q | ex_ready) & ~load_use & ~flush;

    operand_forward u_fwd_rs1 (
        .src_addr_i      (id_rs1_addr),
        .rf_data_i       (id_rs1_data),
        .ex_valid_i      (ex_valid_q),
        .ex_reg_write_i  (ex_rw_q),
        .ex_mem_read_i   (ex_mr_q),
        .ex_rd_addr_i    (ex_rd_q),
        .ex_result_i     (ex_alu_result),
        .mem_reg_write_i (mem_reg_write),
        .mem_rd_addr_i   (mem_rd_addr),
        .mem_result_i    (mem_result),
        .fwd_data_o      (fwd_rs1)
    );

    operand_forward u_fwd_rs2 (
        .src_addr_i      (id_rs2_addr),
        .rf_data_i       (id_rs2_data),
        .ex_valid_i      (ex_valid_q),
        .ex_reg_write_i  (ex_rw_q),
        .ex_mem_read_i   (ex_mr_q),
        .ex_rd_addr_i    (ex_rd_q),
        .ex_result_i     (ex_alu_result),
        .mem_reg_write_i (mem_reg_write),
        .mem_rd_addr_i   (mem_rd_addr),
        .mem_result_i    (mem_result),
        .fwd_data_o      (fwd_rs2)
    );

    // Flush beats hold, hold beats bubble, bubble beats capture.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_sd_d    = ex_sd_q;
        ex_ctl_d   = ex_ctl_q;
        ex_rd_d    = ex_rd_q;
        ex_rw_d    = ex_rw_q;
        ex_mr_d    = ex_mr_q;
        stall_d    = stall_q;
        if (flush) begin
            ex_valid_d = 1'b0;
            ex_rw_d    = 1'b0;
            ex_mr_d    = 1'b0;
        end else if (!hold) begin
            if (load_use) begin
                ex_valid_d = 1'b0;
                ex_rw_d    = 1'b0;
                ex_mr_d    = 1'b0;
                stall_d    = sat_inc(stall_q);
            end else if (id_valid) begin
                ex_valid_d = 1'b1;
                ex_a_d     = fwd_rs1;
                ex_b_d     = id_alu_src ? id_imm : fwd_rs2;
                ex_sd_d    = fwd_rs2;
                ex_ctl_d   = id_alu_control;
                ex_rd_d    = id_rd_addr;
                ex_rw_d    = id_reg_write;
                ex_mr_d    = id_mem_read;
            end else begin
                ex_valid_d = 1'b0;
                ex_rw_d    = 1'b0;
                ex_mr_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q <= 1'b0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_sd_q    <= '0;
            ex_ctl_q   <= ALU_ADD;
            ex_rd_q    <= '0;
            ex_rw_q    <= 1'b0;
            ex_mr_q    <= 1'b0;
            stall_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_sd_q    <= ex_sd_d;
            ex_ctl_q   <= ex_ctl_d;
            ex_rd_q    <= ex_rd_d;
            ex_rw_q    <= ex_rw_d;
            ex_mr_q    <= ex_mr_d;
            stall_q    <= stall_d;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_a           = ex_a_q;
    assign ex_b           = ex_b_q;
    assign ex_store_data  = ex_sd_q;
    assign ex_alu_control = ex_ctl_q;
    assign ex_rd_addr     = ex_rd_q;
    assign ex_reg_write   = ex_rw_q;
    assign ex_mem_read    = ex_mr_q;
    assign stall_count    = stall_q;

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port id_valid, input, 1 bit: decode holds a valid instruction.
REQ-004 SHALL have port id_ready, output, 1 bit: stage accepts the decode instruction this cycle.
REQ-005 SHALL have ports id_rs1_addr and id_rs2_addr, input, 5 bits each: source register indices.
REQ-006 SHALL have ports id_rs1_data and id_rs2_data, input, 32 bits each: register-file read data.
REQ-007 SHALL have port id_imm, input, 32 bits: sign-extended immediate.
REQ-008 SHALL have inputs id_rd_addr (5 bits), id_alu_src (1 bit, 1 selects immediate for B), id_alu_control (3 bits), id_reg_write (1 bit) and id_mem_read (1 bit).
REQ-009 SHALL have port flush, input, 1 bit: kill the captured and incoming instruction.
REQ-010 SHALL have port ex_ready, input, 1 bit: the EX/MEM side accepts the held instruction.
REQ-011 SHALL have port ex_alu_result, input, 32 bits: the ALU Result for the held instruction.
REQ-012 SHALL have inputs mem_rd_addr (5 bits), mem_reg_write (1 bit) and mem_result (32 bits, including load data): the MEM-stage writeback.
REQ-013 SHALL have outputs ex_valid (1 bit), ex_a (32 bits), ex_b (32 bits), ex_store_data (32 bits), ex_alu_control (3 bits), ex_rd_addr (5 bits), ex_reg_write (1 bit) and ex_mem_read (1 bit), all registered.
REQ-014 SHALL have output stall_count, 16 bits: saturating load-use stall counter.

Function
REQ-015 SHALL capture on a clock edge when id_valid & id_ready; id_ready = (~ex_valid | ex_ready) & ~load_use & ~flush.
REQ-016 SHALL compute load_use = ex_valid & ex_mem_read & (ex_rd_addr != 0) & id_valid & ((id_rs1_addr == ex_rd_addr) | (id_rs2_addr == ex_rd_addr)).
REQ-017 SHALL insert a bubble on load_use when ex_ready = 1: ex_valid <= 0 for one cycle and stall_count increments (holds at 0xFFFF).
REQ-018 SHALL hold every output unchanged while ex_valid & ~ex_ready, regardless of id_valid.
REQ-019 SHALL make ex_valid 0 on the next edge when flush = 1, with flush winning over capture, hold and load_use; stall_count does not increment.
REQ-020 SHALL load ex_valid <= 0 when no capture, hold or bubble applies.
REQ-021 SHALL forward each source at capture time, in priority order:
- (a) ex_alu_result, when ex_valid & ex_reg_write & ~ex_mem_read & (ex_rd_addr == src) & (src != 0);
- (b) mem_result, when mem_reg_write & (mem_rd_addr == src) & (src != 0);
- (c) register-file data.
REQ-022 SHALL never forward for index 0; forwarded x0 reads use id data as supplied.
REQ-023 SHALL set ex_a = fwd_rs1, ex_b = id_alu_src ? id_imm : fwd_rs2 and ex_store_data = fwd_rs2.
REQ-024 SHALL have 1-cycle latency from accept to ex_valid, with one accept per cycle max and no combinational path from ex_ready to ex_* outputs.
REQ-025 SHALL force ex_reg_write and ex_mem_read to 0 whenever ex_valid is 0.

Reset
REQ-026 SHALL, while rst = 0, hold all ex_* outputs at 0, ex_alu_control at 3'b000 and stall_count at 0, asynchronously.
REQ-027 SHALL discard any in-flight instruction on reset assertion mid-operation; the first capture is possible on the first edge after rst deasserts.

Structure
REQ-028 SHALL take the ALU control encodings (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101) and the 2-bit forward-select encoding (REG, MEM, EX) from the shared datapath package.
REQ-029 SHALL implement forwarding in one sub-module, operand_forward, instanced once per source operand.

Verification
REQ-030 SHALL verify EX forwarding: the held instruction ADD x5 with ex_alu_result = 0x0000_0010, then SUB reading rs1 = x5 with id_rs1_data = 0 -> ex_a = 0x0000_0010 next cycle.
REQ-031 SHALL verify priority: EX and MEM both target x7 (EX 0x11, MEM 0x22) -> ex_a = 0x11; with x0 in both, rs1 = x0 with id_rs1_data = 0 -> ex_a = 0.
REQ-032 SHALL verify load-use: a load to x3 is held and the next instruction reads x3 -> id_ready = 0 one cycle, bubble, stall_count = 1, then ex_a = mem_result = 0xDEAD_BEEF.
REQ-033 SHALL verify backpressure: ex_ready = 0 for 3 cycles with id_valid = 1 -> outputs stable, id_ready = 0, no instruction lost or duplicated.
REQ-034 SHALL verify flush: flush coincides with load_use and capture -> ex_valid = 0 next cycle and stall_count unchanged.
REQ-035 SHALL verify reset: rst pulled low mid-stream -> all outputs 0 immediately, without waiting for clk.
